// File: rtl/gnn_pkg.sv
// gnn_pkg: shared widths, loader FSM state type and slot-index helpers
// for the 4-node GNN input loader (x/w bus slot mapping).
package gnn_pkg;

  localparam int DW       = 5;
  localparam int N_NODES  = 4;
  localparam int N_FEAT   = 4;
  localparam int N_XWORDS = N_NODES * N_FEAT;
  localparam int N_WWORDS = 24;
  localparam int N_WORDS  = N_XWORDS + N_WWORDS;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_FIRE,
    ST_WAIT
  } loader_state_t;

  // x{feat}_node{node} -> x_out slot
  function automatic int x_slot(int node, int feat);
    return N_FEAT * node + feat;
  endfunction

  // w{i}{j} -> w_out slot
  function automatic int w_slot(int i, int j);
    if (j < 8)
      return 4 * (j - 4) + i;
    else if (j == 8)
      return 16 + (i - 4);
    else
      return 20 + (i - 4);
  endfunction

endpackage

// File: rtl/gnn_input_loader.sv
// gnn_input_loader: framed valid/ready word stream -> registered x_out
// (16 slots) / w_out (24 slots), one-cycle in_ready, busy until gnn_done,
// err on bad frame length or done timeout. Ports: clk, rst (sync, high),
// s_valid/s_ready/s_data/s_last, x_out, w_out, in_ready, gnn_done, busy,
// err. Option GNN_LOADER_WEIGHT_REUSE_EN: after the first good 40-word
// frame, frames carry only the 16 features and w_out is retained.
module gnn_input_loader
  import gnn_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DW-1:0]          s_data,
  input  logic                   s_last,
  output logic [N_XWORDS*DW-1:0] x_out,
  output logic [N_WWORDS*DW-1:0] w_out,
  output logic                   in_ready,
  input  logic                   gnn_done,
  output logic                   busy,
  output logic                   err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  loader_state_t state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [DW-1:0] x_q [N_XWORDS];
  logic [DW-1:0] x_d [N_XWORDS];
  logic [DW-1:0] w_q [N_WWORDS];
  logic [DW-1:0] w_d [N_WWORDS];
  logic          s_ready_q, s_ready_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [5:0]    last_idx;
  logic [4:0]    w_idx;
  logic          xfer;

`ifdef GNN_LOADER_WEIGHT_REUSE_EN
  logic wgt_loaded_q, wgt_loaded_d;
  assign last_idx = wgt_loaded_q ? 6'(N_XWORDS - 1) : 6'(N_WORDS - 1);
`else
  assign last_idx = 6'(N_WORDS - 1);
`endif

  // s_ready_q is only high in LOAD, so it alone qualifies a transfer
  assign xfer  = s_valid && s_ready_q;
  assign w_idx = 5'(cnt_q - 6'(N_XWORDS));

  // next-state and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    x_d     = x_q;
    w_d     = w_q;
    err_d   = 1'b0;
`ifdef GNN_LOADER_WEIGHT_REUSE_EN
    wgt_loaded_d = wgt_loaded_q;
`endif
    unique case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          if (cnt_q < 6'(N_XWORDS))
            x_d[cnt_q[3:0]] = s_data;
          else
            w_d[w_idx] = s_data;
          if (cnt_q == last_idx && s_last) begin
            state_d = ST_FIRE;
            cnt_d   = '0;
`ifdef GNN_LOADER_WEIGHT_REUSE_EN
            wgt_loaded_d = 1'b1;
`endif
          end else if (cnt_q == last_idx || s_last) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_FIRE: begin
        state_d = ST_WAIT;
        tmr_d   = '0;
      end
      ST_WAIT: begin
        // first WAIT cycle (tmr 0) may see stale done flags
        if (tmr_q != '0 && gnn_done) begin
          state_d = ST_LOAD;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_LOAD;
          err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // registered outputs decoded from next state
  always_comb begin
    s_ready_d  = (state_d == ST_LOAD);
    in_ready_d = (state_d == ST_FIRE);
    busy_d     = (state_d != ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      tmr_q      <= '0;
      s_ready_q  <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < N_XWORDS; i++) x_q[i] <= '0;
      for (int i = 0; i < N_WWORDS; i++) w_q[i] <= '0;
`ifdef GNN_LOADER_WEIGHT_REUSE_EN
      wgt_loaded_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      s_ready_q  <= s_ready_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      x_q        <= x_d;
      w_q        <= w_d;
`ifdef GNN_LOADER_WEIGHT_REUSE_EN
      wgt_loaded_q <= wgt_loaded_d;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < N_XWORDS; i++) x_out[i*DW +: DW] = x_q[i];
    for (int i = 0; i < N_WWORDS; i++) w_out[i*DW +: DW] = w_q[i];
  end

  assign s_ready  = s_ready_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule
